// File: rtl/ysyx_25040111_imem_resp_if.sv
// Fetch handshake and RAM preload port between an IFU/loader and the
// instruction-memory responder.
interface ysyx_25040111_imem_resp_if;
   logic        if_start;
   logic [31:0] pc;
   logic [31:0] inst_t;
   logic        if_ok;
   logic        if_err;
   logic        busy;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [15:0] drop_cnt;

   modport master (
      output if_start, pc, wr_en, wr_addr, wr_data,
      input  inst_t, if_ok, if_err, busy, drop_cnt
   );

   modport slave (
      input  if_start, pc, wr_en, wr_addr, wr_data,
      output inst_t, if_ok, if_err, busy, drop_cnt
   );
endinterface

// File: rtl/ysyx_25040111_imem_resp.sv
// Instruction-memory responder: answers one fetch at a time from a
// word-addressed RAM after a fixed latency, returning ebreak on faulting fetches.
module ysyx_25040111_imem_resp #(
   parameter int          LATENCY  = 2,
   parameter int          DEPTH    = 1024,
   parameter logic [31:0] BASE     = 32'h80000000,
   parameter logic [31:0] ERR_INST = 32'h00100073
) (
   input logic                       clk,
   input logic                       reset,
   ysyx_25040111_imem_resp_if.slave  bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [15:0]       r_cnt;
   logic [31:0]       r_pc;
   logic [31:0]       r_inst;
   logic              r_err;
   logic [15:0]       r_drop;
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept;
   logic              w_enterResp;
   logic [31:0]       w_rdAddr;
   logic              w_rdOk;
   logic              w_wrOk;

   function automatic logic inRange(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH)) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [IDX_W-1:0] wordIdx(input logic [31:0] a);
      return IDX_W'((a - BASE) >> 2);
   endfunction

   always_comb begin
      w_stateNext = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.if_start) begin
               w_accept    = 1'b1;
               w_stateNext = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == 16'd1) w_stateNext = RESP;
         end
         RESP:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // With LATENCY==1 the RAM is read at the accept edge, before r_pc is loaded.
   assign w_enterResp = (w_stateNext == RESP) && (r_state != RESP);
   assign w_rdAddr    = (r_state == IDLE) ? bus.pc : r_pc;
   assign w_rdOk      = inRange(w_rdAddr);
   assign w_wrOk      = inRange(bus.wr_addr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= 16'd0;
         r_pc   <= 32'd0;
         r_inst <= 32'd0;
         r_err  <= 1'b0;
         r_drop <= 16'd0;
      end else begin
         if (w_accept) begin
            r_pc  <= bus.pc;
            r_cnt <= 16'(LATENCY - 1);
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 16'd1;
         end
         // Non-blocking read here sees the RAM before any same-edge write.
         if (w_enterResp) begin
            if (w_rdOk) begin
               r_inst <= r_mem[wordIdx(w_rdAddr)];
               r_err  <= 1'b0;
            end else begin
               r_inst <= ERR_INST;
               r_err  <= 1'b1;
            end
         end
         if (bus.if_start && (r_state != IDLE) && (r_drop != 16'hFFFF))
            r_drop <= r_drop + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.wr_en && w_wrOk) r_mem[wordIdx(bus.wr_addr)] <= bus.wr_data;
   end

   assign bus.inst_t   = r_inst;
   assign bus.if_ok    = (r_state == RESP);
   assign bus.if_err   = r_err;
   assign bus.busy     = (r_state != IDLE);
   assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_ysyx_25040111_imem_resp.sv
// Directed bench for the instruction-memory responder; a LATENCY=2 and a
// LATENCY=1 instance share the same stimulus.
module tb_ysyx_25040111_imem_resp;

   localparam logic [31:0] ERR = 32'h00100073;

   logic        clk;
   logic        reset;
   logic        tbStart;
   logic [31:0] tbPc;
   logic        tbWrEn;
   logic [31:0] tbWrAddr;
   logic [31:0] tbWrData;
   int          nTests;
   int          nFail;

   ysyx_25040111_imem_resp_if bus2 ();
   ysyx_25040111_imem_resp_if bus1 ();

   assign bus2.if_start = tbStart;
   assign bus2.pc       = tbPc;
   assign bus2.wr_en    = tbWrEn;
   assign bus2.wr_addr  = tbWrAddr;
   assign bus2.wr_data  = tbWrData;
   assign bus1.if_start = tbStart;
   assign bus1.pc       = tbPc;
   assign bus1.wr_en    = tbWrEn;
   assign bus1.wr_addr  = tbWrAddr;
   assign bus1.wr_data  = tbWrData;

   ysyx_25040111_imem_resp #(.LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
   ysyx_25040111_imem_resp #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic writeWord(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      tbWrEn = 1'b1; tbWrAddr = a; tbWrData = d;
      @(negedge clk);
      tbWrEn = 1'b0;
   endtask

   // Pulse one fetch, then watch a bounded window; lat counts edges from the accept edge (0 = never answered).
   task automatic runFetch(input logic [31:0] a,
                           output int lat2, output int okc2, output logic [31:0] inst2, output logic err2,
                           output int lat1, output int okc1, output logic [31:0] inst1, output logic err1);
      lat2 = 0; okc2 = 0; inst2 = 32'hx; err2 = 1'bx;
      lat1 = 0; okc1 = 0; inst1 = 32'hx; err1 = 1'bx;
      @(negedge clk);
      tbStart = 1'b1; tbPc = a;
      @(negedge clk);
      tbStart = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (bus2.if_ok === 1'b1) begin
            okc2++;
            if (lat2 == 0) begin lat2 = k; inst2 = bus2.inst_t; err2 = bus2.if_err; end
         end
         if (bus1.if_ok === 1'b1) begin
            okc1++;
            if (lat1 == 0) begin lat1 = k; inst1 = bus1.inst_t; err1 = bus1.if_err; end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      @(negedge clk);
      nTests++; if (bus2.inst_t !== 32'd0) begin nFail++; $display("[TB] FAIL reset_inst: got %h expected %h", bus2.inst_t, 32'd0); end
      nTests++; if (bus2.if_ok !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ok: got %b expected 0", bus2.if_ok); end
      nTests++; if (bus2.if_err !== 1'b0) begin nFail++; $display("[TB] FAIL reset_err: got %b expected 0", bus2.if_err); end
      nTests++; if (bus2.busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus2.busy); end
      nTests++; if (bus2.drop_cnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_drop: got %0d expected 0", bus2.drop_cnt); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic;
      int lat2, okc2, lat1, okc1;
      logic [31:0] inst2, inst1;
      logic err2, err1;
      writeWord(32'h80000000, 32'h00000413);
      writeWord(32'h80000004, 32'hDEADBEEF);
      writeWord(32'h80000010, 32'h11111111);
      runFetch(32'h80000000, lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
      nTests++; if (lat2 !== 2) begin nFail++; $display("[TB] FAIL basic_latency: got %0d expected 2", lat2); end
      nTests++; if (okc2 !== 1) begin nFail++; $display("[TB] FAIL basic_ok_width: got %0d expected 1", okc2); end
      nTests++; if (inst2 !== 32'h00000413) begin nFail++; $display("[TB] FAIL basic_inst: got %h expected %h", inst2, 32'h00000413); end
      nTests++; if (err2 !== 1'b0) begin nFail++; $display("[TB] FAIL basic_err: got %b expected 0", err2); end
      nTests++; if (bus2.inst_t !== 32'h00000413) begin nFail++; $display("[TB] FAIL basic_hold: got %h expected %h", bus2.inst_t, 32'h00000413); end
      nTests++; if (bus2.busy !== 1'b0) begin nFail++; $display("[TB] FAIL basic_idle_busy: got %b expected 0", bus2.busy); end
   endtask

   task automatic test_faults;
      logic [31:0] pcs [3];
      int lat2, okc2, lat1, okc1;
      logic [31:0] inst2, inst1;
      logic err2, err1;
      pcs[0] = 32'h80000002;
      pcs[1] = 32'h7FFFFFFC;
      pcs[2] = 32'h80001000;
      for (int i = 0; i < 3; i++) begin
         runFetch(pcs[i], lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
         nTests++; if (okc2 !== 1) begin nFail++; $display("[TB] FAIL fault_ok pc=%h: got %0d expected 1", pcs[i], okc2); end
         nTests++; if (err2 !== 1'b1) begin nFail++; $display("[TB] FAIL fault_err pc=%h: got %b expected 1", pcs[i], err2); end
         nTests++; if (inst2 !== ERR) begin nFail++; $display("[TB] FAIL fault_inst pc=%h: got %h expected %h", pcs[i], inst2, ERR); end
      end
   endtask

   task automatic test_drops;
      int lat2, okc2, lat1, okc1;
      logic [31:0] inst2, inst1;
      logic err2, err1;
      @(negedge clk);
      tbStart = 1'b1; tbPc = 32'h80000000;
      @(negedge clk);
      tbPc = 32'h80000004;
      @(negedge clk);
      nTests++; if (bus2.if_ok !== 1'b1) begin nFail++; $display("[TB] FAIL drop_first_ok: got %b expected 1", bus2.if_ok); end
      nTests++; if (bus2.inst_t !== 32'h00000413) begin nFail++; $display("[TB] FAIL drop_first_inst: got %h expected %h", bus2.inst_t, 32'h00000413); end
      @(negedge clk);
      tbStart = 1'b0;
      nTests++; if (bus2.drop_cnt !== 16'd2) begin nFail++; $display("[TB] FAIL drop_cnt: got %0d expected 2", bus2.drop_cnt); end
      nTests++; if (bus2.busy !== 1'b0) begin nFail++; $display("[TB] FAIL drop_idle: got %b expected 0", bus2.busy); end
      repeat (2) @(negedge clk);
      runFetch(32'h80000004, lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
      nTests++; if (inst2 !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL drop_next_inst: got %h expected %h", inst2, 32'hDEADBEEF); end
      nTests++; if (bus2.drop_cnt !== 16'd2) begin nFail++; $display("[TB] FAIL drop_cnt_stable: got %0d expected 2", bus2.drop_cnt); end
   endtask

   task automatic test_write_race;
      int lat2, okc2, lat1, okc1;
      logic [31:0] inst2, inst1;
      logic err2, err1;
      // Write lands on the accept edge, one edge ahead of the read.
      @(negedge clk);
      tbStart = 1'b1; tbPc = 32'h80000010;
      tbWrEn = 1'b1; tbWrAddr = 32'h80000010; tbWrData = 32'hAAAAAAAA;
      @(negedge clk);
      tbStart = 1'b0; tbWrEn = 1'b0;
      @(negedge clk);
      nTests++; if (bus2.if_ok !== 1'b1) begin nFail++; $display("[TB] FAIL race_early_ok: got %b expected 1", bus2.if_ok); end
      nTests++; if (bus2.inst_t !== 32'hAAAAAAAA) begin nFail++; $display("[TB] FAIL race_early_inst: got %h expected %h", bus2.inst_t, 32'hAAAAAAAA); end
      repeat (2) @(negedge clk);
      writeWord(32'h80000010, 32'h11111111);
      @(negedge clk);
      tbStart = 1'b1; tbPc = 32'h80000010;
      @(negedge clk);
      tbStart = 1'b0;
      tbWrEn = 1'b1; tbWrAddr = 32'h80000010; tbWrData = 32'hAAAAAAAA;
      @(negedge clk);
      tbWrEn = 1'b0;
      nTests++; if (bus2.if_ok !== 1'b1) begin nFail++; $display("[TB] FAIL race_same_ok: got %b expected 1", bus2.if_ok); end
      nTests++; if (bus2.inst_t !== 32'h11111111) begin nFail++; $display("[TB] FAIL race_same_inst: got %h expected %h", bus2.inst_t, 32'h11111111); end
      repeat (2) @(negedge clk);
      runFetch(32'h80000010, lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
      nTests++; if (inst2 !== 32'hAAAAAAAA) begin nFail++; $display("[TB] FAIL race_write_landed: got %h expected %h", inst2, 32'hAAAAAAAA); end
   endtask

   task automatic test_reset_mid_wait;
      int lat2, okc2, lat1, okc1, stray;
      logic [31:0] inst2, inst1;
      logic err2, err1;
      @(negedge clk);
      tbStart = 1'b1; tbPc = 32'h80000004;
      @(negedge clk);
      tbStart = 1'b0;
      nTests++; if (bus2.busy !== 1'b1) begin nFail++; $display("[TB] FAIL abort_busy_before: got %b expected 1", bus2.busy); end
      reset = 1'b0;
      #1;
      nTests++; if (bus2.busy !== 1'b0) begin nFail++; $display("[TB] FAIL abort_busy: got %b expected 0", bus2.busy); end
      nTests++; if (bus2.inst_t !== 32'd0) begin nFail++; $display("[TB] FAIL abort_inst: got %h expected 0", bus2.inst_t); end
      @(negedge clk);
      reset = 1'b1;
      stray = 0;
      for (int k = 0; k < 4; k++) begin
         if (bus2.if_ok !== 1'b0) stray++;
         @(negedge clk);
      end
      nTests++; if (stray !== 0) begin nFail++; $display("[TB] FAIL abort_no_ok: got %0d strobes expected 0", stray); end
      runFetch(32'h80000004, lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
      nTests++; if (lat2 !== 2) begin nFail++; $display("[TB] FAIL abort_refetch_lat: got %0d expected 2", lat2); end
      nTests++; if (inst2 !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL abort_refetch_inst: got %h expected %h", inst2, 32'hDEADBEEF); end
   endtask

   task automatic test_latency1;
      int lat2, okc2, lat1, okc1;
      logic [31:0] inst2, inst1;
      logic err2, err1;
      runFetch(32'h80000000, lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
      nTests++; if (lat1 !== 1) begin nFail++; $display("[TB] FAIL l1_latency: got %0d expected 1", lat1); end
      nTests++; if (okc1 !== 1) begin nFail++; $display("[TB] FAIL l1_ok_width: got %0d expected 1", okc1); end
      nTests++; if (inst1 !== 32'h00000413) begin nFail++; $display("[TB] FAIL l1_inst: got %h expected %h", inst1, 32'h00000413); end
      nTests++; if (err1 !== 1'b0) begin nFail++; $display("[TB] FAIL l1_err: got %b expected 0", err1); end
      runFetch(32'h80001000, lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
      nTests++; if (err1 !== 1'b1) begin nFail++; $display("[TB] FAIL l1_fault_err: got %b expected 1", err1); end
      nTests++; if (inst1 !== ERR) begin nFail++; $display("[TB] FAIL l1_fault_inst: got %h expected %h", inst1, ERR); end
      @(negedge clk);
      tbStart = 1'b1; tbPc = 32'h80000004;
      @(negedge clk);
      tbStart = 1'b0;
      nTests++; if (bus1.if_ok !== 1'b1) begin nFail++; $display("[TB] FAIL l1_resp_ok: got %b expected 1", bus1.if_ok); end
      reset = 1'b0;
      #1;
      nTests++; if (bus1.if_ok !== 1'b0) begin nFail++; $display("[TB] FAIL l1_abort_ok: got %b expected 0", bus1.if_ok); end
      @(negedge clk);
      reset = 1'b1;
      runFetch(32'h80000004, lat2, okc2, inst2, err2, lat1, okc1, inst1, err1);
      nTests++; if (lat1 !== 1) begin nFail++; $display("[TB] FAIL l1_refetch_lat: got %0d expected 1", lat1); end
      nTests++; if (inst1 !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL l1_refetch_inst: got %h expected %h", inst1, 32'hDEADBEEF); end
   endtask

   initial begin
      nTests = 0; nFail = 0;
      tbStart = 1'b0; tbPc = 32'd0;
      tbWrEn = 1'b0; tbWrAddr = 32'd0; tbWrData = 32'd0;
      reset = 1'b0;
      test_reset();
      test_basic();
      test_faults();
      test_drops();
      test_write_race();
      test_reset_mid_wait();
      test_latency1();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
